// File: rtl/score_display_if.sv
// Scoreboard bus between game logic and the seven-segment display driver.
// Carries the scores and game state in, and the display pins and busy flag out.
interface score_display_if;
    logic [3:0] R_score;
    logic [3:0] L_score;
    logic [3:0] state;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       busy;

    modport master (
        output R_score, L_score, state,
        input  seg, an, dp, busy
    );

    modport slave (
        input  R_score, L_score, state,
        output seg, an, dp, busy
    );
endinterface

// File: rtl/score_display.sv
// Four-digit multiplexed seven-segment scoreboard with optional point blink.
// Blink FSM is built only when SCORE_BLINK_EN is defined.
module score_display #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000,
    parameter int BLINK_CNT = 3
) (
    input  logic            clk,
    input  logic            rst,
    score_display_if.slave  bus
);
    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

    if (SCAN_DIV < 2 || BLINK_DIV < 2 || BLINK_CNT < 1) begin : g_cfg_bad
        $error("score_display: invalid divider configuration");
    end

    logic [3:0]    r_q, l_q, st_q;
    logic [3:0]    r_prev_q, l_prev_q;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          dp_q, dp_d;
    logic          busy_q, busy_d;
    logic [3:0]    blank_mask;

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] ones(input logic [3:0] s);
        return (s >= 4'd10) ? s - 4'd10 : s;
    endfunction

    // tens digit is either blank or a '1' for scores 10..15
    function automatic logic [6:0] tens_seg(input logic [3:0] s);
        return (s >= 4'd10) ? enc(4'd1) : 7'h7F;
    endfunction

    // digit scan counter and index
    always_comb begin
        scan_cnt_d = scan_cnt_q + SW'(1);
        idx_d      = idx_q;
        if (scan_cnt_q == SCAN_MAX) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
        end
    end

    // segment, separator and digit-enable selection for the current digit
    always_comb begin
        seg_d = 7'h7F;
        unique case (idx_q)
            2'd0: seg_d = enc(ones(r_q));
            2'd1: seg_d = tens_seg(r_q);
            2'd2: seg_d = enc(ones(l_q));
            2'd3: seg_d = tens_seg(l_q);
            default: seg_d = 7'h7F;
        endcase
        dp_d = ~((idx_q == 2'd2) && (st_q != 4'd0));
        an_d = ~(4'b0001 << idx_q) | blank_mask;
    end

`ifdef SCORE_BLINK_EN
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam int PW = $clog2(BLINK_CNT + 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
    localparam logic [PW-1:0] PER_LAST  = PW'(BLINK_CNT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BLINK_R = 2'd1,
        BLINK_L = 2'd2
    } blink_t;

    blink_t        fsm_q, fsm_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;
    logic [PW-1:0] per_q, per_d;

    // blink sequencing: a new point restarts the sequence on its side
    always_comb begin
        fsm_d   = fsm_q;
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        per_d   = per_q;
        if (st_q == 4'd0 || r_q != r_prev_q || l_q != l_prev_q) begin
            bcnt_d  = '0;
            phase_d = 1'b0;
            per_d   = '0;
            if (st_q == 4'd0)         fsm_d = IDLE;
            else if (r_q != r_prev_q) fsm_d = BLINK_R;
            else                      fsm_d = BLINK_L;
        end else if (fsm_q != IDLE) begin
            if (bcnt_q == BLINK_MAX) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (per_q == PER_LAST) begin
                        fsm_d = IDLE;
                        per_d = '0;
                    end else begin
                        per_d = per_q + PW'(1);
                    end
                end
            end else begin
                bcnt_d = bcnt_q + BW'(1);
            end
        end
    end

    // blank the scoring side during the off half of each period
    always_comb begin
        blank_mask = 4'b0000;
        if (!phase_d) begin
            if (fsm_d == BLINK_R) blank_mask = 4'b0011;
            if (fsm_d == BLINK_L) blank_mask = 4'b1100;
        end
        busy_d = (fsm_d != IDLE);
    end

    // blink state registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm_q   <= IDLE;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            per_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            per_q   <= per_d;
        end
    end
`else
    assign blank_mask = 4'b0000;
    assign busy_d     = 1'b0;
`endif

    // input sampling, scan state and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q        <= '0;
            l_q        <= '0;
            st_q       <= '0;
            r_prev_q   <= '0;
            l_prev_q   <= '0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            seg_q      <= 7'h7F;
            an_q       <= 4'hF;
            dp_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            r_q        <= bus.R_score;
            l_q        <= bus.L_score;
            st_q       <= bus.state;
            r_prev_q   <= r_q;
            l_prev_q   <= l_q;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            dp_q       <= dp_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.seg  = seg_q;
    assign bus.an   = an_q;
    assign bus.dp   = dp_q;
    assign bus.busy = busy_q;
endmodule

// File: doc/score_display.md
# score_display

Four-digit multiplexed seven-segment scoreboard for the ping-pong game. It sits directly downstream of the game FSM and score logic, and consumes the 4-bit right/left scores and the 4-bit game state. It drives a common-anode four-digit display with both scores, and blinks the scoring side's digits when a point is won. All outputs are registered and driven from one clock.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each digit stays enabled; must be ≥ 2.
- `BLINK_DIV`, default 25000000: clock cycles per blink half-period (off half, then on half); must be ≥ 2.
- `BLINK_CNT`, default 3: number of full off/on blink periods per point.
- `clk`  input  1: system clock; all logic on its rising edge.
- `rst`  input  1: one clock; reset is synchronous and active-low (`rst`=0 resets on the next `clk` rising edge).
- `R_score`  input  4: right player score, 0..15, unsigned.
- `L_score`  input  4: left player score, 0..15, unsigned.
- `state`  input  4: game state code; 0 = init, all other values = game active.
- `seg`  output  7: segments {g,f,e,d,c,b,a}, active-low.
- `an`  output  4: digit enables, active-low; an[0]=R ones, an[1]=R tens, an[2]=L ones, an[3]=L tens.
- `dp`  output  1: decimal point, active-low; used as the L/R separator.
- `busy`  output  1: high while a blink sequence is in progress.

## Operation
- **Input sampling:** `R_score`, `L_score` and `state` are registered every cycle into `r_q`, `l_q` and `st_q`. The previous-score registers `r_prev` and `l_prev` hold the prior `r_q` and `l_q`.
- **Digit split:** tens = (score ≥ 10) ? 1 : 0; ones = score − 10·tens.
- **Leading-zero blanking:** when tens = 0, the tens digit is blank (`seg`=7'h7F), but its `an` bit is still asserted.
- **Segment encoding**, 0..9 as {g..a}, active-low: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10 (hex).
- **Scan:** the 2-bit `idx` advances 0→1→2→3→0 each time `scan_cnt` reaches SCAN_DIV−1; `scan_cnt` then returns to 0. Exactly one `an` bit is low at a time.
- **`dp`:** low only while `idx`=2 and `st_q`≠0; high otherwise.
- **Blink FSM states:** IDLE, BLINK_R, BLINK_L.
  - IDLE→BLINK_R when `r_q`≠`r_prev` and `st_q`≠0.
  - IDLE→BLINK_L when `l_q`≠`l_prev` and `st_q`≠0.
  - If both sides change in the same cycle, R has priority.
  - A change on either side during a blink restarts the FSM in the new side's state, with the counters cleared.
  - `st_q`=0 forces IDLE from any state.
  - After BLINK_CNT periods the FSM returns to IDLE.
- **Blink counters:** `blink_cnt` counts 0..BLINK_DIV−1, and `phase` toggles at wrap. `periods` increments each time `phase` returns to 0. Exit when `periods` = BLINK_CNT.
- **Blanking during a blink:** while `phase`=0 (off half) in BLINK_R, an[1:0] are forced high. In BLINK_L, an[3:2] are forced high. The scan keeps running.
- **`busy`:** `busy` = (FSM ≠ IDLE).
- **Reset values:**
  - Outputs: `an`=4'hF, `seg`=7'h7F, `dp`=1, `busy`=0.
  - Internal: `idx`=0, all counters 0, FSM=IDLE.
  - Registered inputs: `r_q`, `l_q`, `r_prev`, `l_prev` and `st_q` all cleared to 0.
- **Reset mid-blink:** the FSM returns to IDLE and all outputs take their reset values on the same edge.

## Timing
- **Outputs:** all outputs are registered.
- **Score-change latency:**
  - Input change → registered value: 1 cycle.
  - Registered value → visible on its digit: at most 4·SCAN_DIV + 1 cycles.
- **Score change → `busy`:** `busy` rises 2 cycles after the score input changes (input register, then the prev-compare).
- **First cycle after reset release:** `an`=4'b1110, showing the R ones digit.
- **Blink length:** 2·BLINK_DIV·BLINK_CNT cycles from `busy` rising to `busy` falling.
- **Scan period:** 4·SCAN_DIV cycles.

## Configuration
- **`SCORE_BLINK_EN` defined:** the blink FSM, its counters and `busy` behave as specified above.
- **`SCORE_BLINK_EN` undefined:**
  - The blink FSM and its counters are not built.
  - `busy` is tied to 0.
  - `an` comes from the scan only, with no blanking.
  - Scan, encoding and `dp` are unchanged.

## Test plan
All scenarios use SCAN_DIV=4, BLINK_DIV=8, BLINK_CNT=3.
- **Reset:** hold `rst`=0 for 3 cycles → `an`=F, `seg`=7F, `dp`=1, `busy`=0. The first cycle after release gives `an`=E, and `an` steps E→D→B→7 every 4 cycles, repeating with period 16.
- **Static display:** R=7, L=12, state=1, steady →
  - `an`=E: `seg`=78.
  - `an`=D: `seg`=7F (blanked tens).
  - `an`=B: `seg`=24 with `dp`=0.
  - `an`=7: `seg`=79.
- **Boundary values:** R=15, L=0, state=1 →
  - R ones: `seg`=12. R tens: `seg`=79.
  - L ones: `seg`=40. L tens: `seg`=7F.
  - With state=0, `dp` stays 1.
- **R blink:** with the macro defined, R 2→3 at state=3 →
  - `busy` rises 2 cycles later.
  - an[1:0] stay high for 8 cycles, then scan normally for 8, repeated 3 times.
  - `busy` falls after 48 cycles.
- **Restart and abort:** during BLINK_R, L changes → restart in BLINK_L with 48 more cycles of `busy`. Then scores go to 0 with state=0 mid-blink → `busy`=0 two cycles later.
- **Macro off:** `SCORE_BLINK_EN` undefined, R changes → `busy` stays 0 and no digit is ever blanked by a blink.
